sqrt_recon: RTL
===============

SQRT_RECON -- requirements
Module: sqrt_recon

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clock and reset.
REQ-002 The block SHALL have no parameters; widths are fixed: root 8 bits, remainder 9 bits, radicand 16 bits.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-low reset; 0 forces the reset state immediately.
REQ-005 enable  input  1  global advance; 0 freezes all state and outputs.
REQ-006 in_valid  input  1  root/rem are valid.
REQ-007 in_ready  output  1  block can accept an operand pair.
REQ-008 root  input  8  square-root result from the sqrt pipeline.
REQ-009 rem  input  9  remainder from the sqrt pipeline.
REQ-010 out_valid  output  1  radicand/error are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 radicand  output  16  reconstructed value root*root + rem.
REQ-013 error  output  1  rem exceeds 2*root (inconsistent sqrt result).

Function
REQ-014 The block SHALL implement states IDLE, MUL, ADD and DONE; it SHALL NOT change state in any cycle where enable=0.
REQ-015 in_ready SHALL equal (state==IDLE) AND enable.
REQ-016 Accept: at a clock edge with in_valid=1 and in_ready=1, the block SHALL latch root (multiplicand), root (multiplier shift register) and rem, clear the 16-bit accumulator and bit counter, and go to MUL.
REQ-017 MUL: on each enabled edge, if multiplier bit 0 is 1, accumulator += multiplicand shifted left by the counter; then multiplier >>= 1 and counter += 1.
REQ-018 MUL SHALL last exactly 8 enabled edges (counter 0..7); on the edge with counter=7 the state SHALL go to ADD.
REQ-019 ADD: on one enabled edge, accumulator += rem (zero-extended to 16 bits), error <= (rem > 2*root) using a 9-bit compare, and state goes to DONE.
REQ-020 Arithmetic SHALL NOT overflow: max 255*255 + 510 = 65535; no saturation logic.
REQ-021 DONE: out_valid SHALL be 1; radicand and error SHALL hold stable until the handshake.
REQ-022 At an edge in DONE with out_ready=1 and enable=1, the block SHALL go to IDLE; out_valid drops on that edge.
REQ-023 With enable held at 1, out_valid SHALL rise on the 10th rising edge counting the accepting edge as edge 1.
REQ-024 in_valid SHALL be ignored outside IDLE; there is no input bypass in DONE.
REQ-025 Throughput SHALL be one result per 11 cycles minimum; a new accept is possible on the edge after the output handshake.
REQ-026 out_valid SHALL NOT depend on enable; it depends only on state.
REQ-027 radicand and error SHALL retain the last result in IDLE and SHALL update only in ADD.

Reset
REQ-028 While reset=0, the block SHALL force state=IDLE, out_valid=0, radicand=0x0000, error=0, and clear the accumulator, counter and operand registers, independent of clock.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no partial result visible.
REQ-030 After reset is released, in_ready SHALL be 1 whenever enable=1.

Verification
REQ-031 The bench SHALL drive root=0xFF, rem=0x1FE, out_ready=1 -> radicand=0xFFFF, error=0, out_valid on the 10th edge.
REQ-032 The bench SHALL drive root=0x00, rem=0x000 -> radicand=0x0000, error=0.
REQ-033 The bench SHALL drive root=0x10, rem=0x021 -> radicand=0x0121, error=1 (33 > 32).
REQ-034 The bench SHALL drive root=0x0C, rem=0x005, with enable=0 for 3 cycles during MUL -> radicand=0x0095, out_valid delayed by exactly 3 cycles, no state change while enable=0.
REQ-035 The bench SHALL hold out_ready=0 for 5 cycles in DONE -> radicand/out_valid stable and in_ready=0; then raise out_ready -> IDLE on the next edge and in_ready=1; a new in_valid is accepted on the following edge.
REQ-036 The bench SHALL pulse reset=0 during MUL of root=0xAA -> out_valid=0 and radicand=0x0000 immediately; after release, in_ready=1 and a fresh root=0x03, rem=0x002 yields radicand=0x000B.

Source files
------------

// File: rtl/sqrt_recon.sv
// Square-root result reconstruction: computes root*root + rem with a serial shift-add
// multiplier and flags remainders larger than 2*root as an inconsistent sqrt result.
module sqrt_recon (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  root,
    input  logic [8:0]  rem,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] radicand,
    output logic        error
);

    typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [8:0]  rem_q, rem_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] radicand_q, radicand_d;
    logic        error_q, error_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            rem_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            radicand_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            radicand_q <= radicand_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        radicand_d = radicand_q;
        error_d    = error_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d  = MUL;
                        mcand_d  = root;
                        mplier_d = root;
                        rem_d    = rem;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end
                end
                MUL: begin
                    if (mplier_q[0])
                        acc_d = acc_q + ({8'h00, mcand_q} << cnt_q);
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 3'd1;
                    if (cnt_q == 3'd7)
                        state_d = ADD;
                end
                ADD: begin
                    // Result registers are written only here so IDLE keeps the last answer.
                    acc_d      = acc_q + {7'h00, rem_q};
                    radicand_d = acc_q + {7'h00, rem_q};
                    error_d    = (rem_q > {mcand_q, 1'b0});
                    state_d    = DONE;
                end
                DONE: begin
                    if (out_ready)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && enable;
        out_valid = (state_q == DONE);
        radicand  = radicand_q;
        error     = error_q;
    end

endmodule
